// File: rtl/aes128_iter_encrypt.sv
// Iterative AES-128 encryption core: ROUNDS_PER_CYCLE unrolled rounds per clock with on-the-fly
// key expansion, valid/ready handshakes on both the plaintext and ciphertext sides.

module aes_sbox (
   input  logic [7:0] byte_val,
   output logic [7:0] sub_val
);
   // Entry 0 sits in the top byte.
   localparam logic [2047:0] TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   assign sub_val = TBL[11'd2047 - {byte_val, 3'b000} -: 8];
endmodule

module aes_round (
   input  logic [127:0] state,
   input  logic [127:0] key,
   input  logic [7:0]   rcon,
   input  logic         last,
   output logic [127:0] next_state,
   output logic [127:0] next_key
);
   logic [127:0] shifted;
   logic [127:0] mixed;
   logic [31:0]  rot_word;
   logic [31:0]  sub_word;
   logic [31:0]  temp;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   // SubBytes and ShiftRows fused: output byte (row r, col c) reads input (r, (c+r)%4).
   for (genvar i = 0; i < 16; i++) begin : g_state_sbox
      localparam int SRC = 4 * (((i / 4) + (i % 4)) % 4) + (i % 4);
      aes_sbox u_sbox (.byte_val(state[127 - 8*SRC -: 8]), .sub_val(shifted[127 - 8*i -: 8]));
   end

   for (genvar c = 0; c < 4; c++) begin : g_mix
      assign mixed[127 - 32*c -: 32] = mix_col(shifted[127 - 32*c -: 32]);
   end

   assign rot_word = {key[23:0], key[31:24]};

   for (genvar j = 0; j < 4; j++) begin : g_key_sbox
      aes_sbox u_sbox (.byte_val(rot_word[31 - 8*j -: 8]), .sub_val(sub_word[31 - 8*j -: 8]));
   end

   assign temp               = sub_word ^ {rcon, 24'h000000};
   assign next_key[127:96]   = key[127:96] ^ temp;
   assign next_key[95:64]    = key[95:64] ^ next_key[127:96];
   assign next_key[63:32]    = key[63:32] ^ next_key[95:64];
   assign next_key[31:0]     = key[31:0] ^ next_key[63:32];
   assign next_state         = (last ? shifted : mixed) ^ next_key;
endmodule

module aes128_iter_encrypt #(
   parameter int unsigned ROUNDS_PER_CYCLE = 1,
   parameter int unsigned OUT_HOLD         = 1
) (
   input  logic         CLK,
   input  logic         RESET_N,
   input  logic         IN_VALID,
   output logic         IN_READY,
   input  logic [127:0] PLAIN_TXT,
   input  logic [127:0] AESKEY,
   output logic         OUT_VALID,
   input  logic         OUT_READY,
   output logic [127:0] CIPHER_TXT,
   output logic         BUSY
);
   if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 &&
       ROUNDS_PER_CYCLE != 5 && ROUNDS_PER_CYCLE != 10) begin : g_bad_rpc
      $error("ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
   end

   typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

   state_t       cur, nxt;
   logic [127:0] state_q, rk_q, ct_q;
   logic [3:0]   rnd_q;
   logic         accept, last_pass;

   logic [ROUNDS_PER_CYCLE:0][127:0] st_chain;
   logic [ROUNDS_PER_CYCLE:0][127:0] key_chain;

   function automatic logic [7:0] rcon_of(input logic [4:0] r);
      case (r)
         5'd1:    return 8'h01;
         5'd2:    return 8'h02;
         5'd3:    return 8'h04;
         5'd4:    return 8'h08;
         5'd5:    return 8'h10;
         5'd6:    return 8'h20;
         5'd7:    return 8'h40;
         5'd8:    return 8'h80;
         5'd9:    return 8'h1b;
         5'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   assign st_chain[0]  = state_q;
   assign key_chain[0] = rk_q;

   for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_round
      logic [4:0] rnum;
      assign rnum = {1'b0, rnd_q} + 5'(g);
      aes_round u_round (
         .state      (st_chain[g]),
         .key        (key_chain[g]),
         .rcon       (rcon_of(rnum)),
         .last       (rnum == 5'd10),
         .next_state (st_chain[g+1]),
         .next_key   (key_chain[g+1])
      );
   end

   assign last_pass = (rnd_q == 4'(11 - ROUNDS_PER_CYCLE));
   assign accept    = IN_VALID && IN_READY;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) cur <= S_IDLE;
      else          cur <= nxt;
   end

   always_comb begin
      nxt       = cur;
      IN_READY  = 1'b0;
      OUT_VALID = 1'b0;
      BUSY      = 1'b0;
      case (cur)
         S_IDLE: begin
            IN_READY = RESET_N;
            if (IN_VALID && RESET_N) nxt = S_ROUND;
         end
         S_ROUND: begin
            BUSY = 1'b1;
            if (last_pass) nxt = S_DONE;
         end
         S_DONE: begin
            BUSY      = 1'b1;
            OUT_VALID = 1'b1;
            if (OUT_READY) nxt = S_IDLE;
         end
         default: nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= '0;
         rk_q    <= '0;
         ct_q    <= '0;
         rnd_q   <= '0;
      end else begin
         case (cur)
            S_IDLE: if (accept) begin
               state_q <= PLAIN_TXT ^ AESKEY;
               rk_q    <= AESKEY;
               rnd_q   <= 4'd1;
            end
            S_ROUND: begin
               state_q <= st_chain[ROUNDS_PER_CYCLE];
               rk_q    <= key_chain[ROUNDS_PER_CYCLE];
               // Final pass parks the counter at 10 instead of stepping past it.
               if (last_pass) begin
                  ct_q  <= st_chain[ROUNDS_PER_CYCLE];
                  rnd_q <= 4'd10;
               end else begin
                  rnd_q <= rnd_q + 4'(ROUNDS_PER_CYCLE);
               end
            end
            S_DONE: if (OUT_READY) rnd_q <= '0;
            default: ;
         endcase
      end
   end

   assign CIPHER_TXT = (OUT_HOLD != 0 || cur == S_DONE) ? ct_q : '0;
endmodule

// File: tb/tb_aes128_iter_encrypt.sv
// Directed bench for aes128_iter_encrypt: known-answer vectors, latency per unroll factor,
// output stall, back-to-back blocks, input churn during rounds and mid-block reset.

module tb_aes128_iter_encrypt;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, ivx, out_ready, orx;
   logic [127:0] pt, key;
   logic         in_ready, out_valid, busy;
   logic [127:0] ct;
   logic [2:0]   rdy_x, ov_x, busy_x;
   logic [127:0] ct2, ct5, ct10;

   always #5 clk = ~clk;

   aes128_iter_encrypt #(.ROUNDS_PER_CYCLE(1), .OUT_HOLD(1)) dut (
      .CLK(clk), .RESET_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
      .PLAIN_TXT(pt), .AESKEY(key), .OUT_VALID(out_valid), .OUT_READY(out_ready),
      .CIPHER_TXT(ct), .BUSY(busy));

   aes128_iter_encrypt #(.ROUNDS_PER_CYCLE(2), .OUT_HOLD(0)) u_rpc2 (
      .CLK(clk), .RESET_N(rst_n), .IN_VALID(ivx), .IN_READY(rdy_x[0]),
      .PLAIN_TXT(pt), .AESKEY(key), .OUT_VALID(ov_x[0]), .OUT_READY(orx),
      .CIPHER_TXT(ct2), .BUSY(busy_x[0]));

   aes128_iter_encrypt #(.ROUNDS_PER_CYCLE(5), .OUT_HOLD(1)) u_rpc5 (
      .CLK(clk), .RESET_N(rst_n), .IN_VALID(ivx), .IN_READY(rdy_x[1]),
      .PLAIN_TXT(pt), .AESKEY(key), .OUT_VALID(ov_x[1]), .OUT_READY(orx),
      .CIPHER_TXT(ct5), .BUSY(busy_x[1]));

   aes128_iter_encrypt #(.ROUNDS_PER_CYCLE(10), .OUT_HOLD(1)) u_rpc10 (
      .CLK(clk), .RESET_N(rst_n), .IN_VALID(ivx), .IN_READY(rdy_x[2]),
      .PLAIN_TXT(pt), .AESKEY(key), .OUT_VALID(ov_x[2]), .OUT_READY(orx),
      .CIPHER_TXT(ct10), .BUSY(busy_x[2]));

   typedef struct {
      logic [127:0] key;
      logic [127:0] pt;
      logic [127:0] ct;
   } vec_t;

   vec_t vecs[3];
   int   checks = 0;
   int   errors = 0;

   task automatic check_v(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic check_i(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int w = 0;
      while (!in_ready && w < 50) begin
         step();
         w++;
      end
      check_v("ready_before_send", in_ready, 1);
   endtask

   task automatic run_block(input logic [127:0] k, input logic [127:0] p,
                            output logic [127:0] c, output int lat);
      wait_ready();
      key = k;
      pt = p;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      lat = -1;
      c = '0;
      for (int i = 1; i <= 40 && lat < 0; i++) begin
         step();
         if (out_valid) begin
            lat = i;
            c = ct;
         end
      end
   endtask

   initial begin
      logic [127:0] got, held;
      int           lat, nacc, nout;
      int           acc_cyc[2];
      logic [127:0] outs[2];
      int           first_ov[3];
      logic         rdy_pre;

      vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                  128'h3925841d02dc09fbdc118597196a0b32};
      vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
      vecs[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

      rst_n = 1'b0; in_valid = 1'b0; ivx = 1'b0; out_ready = 1'b1; orx = 1'b1;
      pt = '0; key = '0;
      #2;
      check_v("rst_in_ready", in_ready, 0);
      check_v("rst_out_valid", out_valid, 0);
      check_v("rst_busy", busy, 0);
      check_v("rst_cipher", ct, 0);
      check_v("rst_ready_x", rdy_x, 0);
      step(); step();
      rst_n = 1'b1;
      #1;
      check_v("idle_in_ready", in_ready, 1);
      check_v("idle_ready_x", rdy_x, 3'b111);

      // Known-answer vectors on the one-round-per-clock core.
      for (int v = 0; v < 3; v++) begin
         run_block(vecs[v].key, vecs[v].pt, got, lat);
         check_v($sformatf("kat%0d_ct", v), got, vecs[v].ct);
         check_i($sformatf("kat%0d_latency", v), lat, 10);
      end

      // Same block on the unrolled variants, all accepted on the same edge.
      step();
      key = vecs[1].key; pt = vecs[1].pt; ivx = 1'b1;
      step();
      ivx = 1'b0;
      first_ov = '{-1, -1, -1};
      for (int i = 1; i <= 15; i++) begin
         if (i == 1) check_v("rpc2_ct_zero_before", ct2, 0);
         step();
         for (int u = 0; u < 3; u++)
            if (ov_x[u] && first_ov[u] < 0) first_ov[u] = i;
         if (i == first_ov[0]) check_v("rpc2_ct", ct2, vecs[1].ct);
         if (i == first_ov[1]) check_v("rpc5_ct", ct5, vecs[1].ct);
         if (i == first_ov[2]) check_v("rpc10_ct", ct10, vecs[1].ct);
      end
      check_i("rpc2_latency", first_ov[0], 5);
      check_i("rpc5_latency", first_ov[1], 2);
      check_i("rpc10_latency", first_ov[2], 1);
      check_v("rpc2_ct_zero_after", ct2, 0);
      check_v("rpc5_ct_held", ct5, vecs[1].ct);
      check_v("extras_idle", rdy_x, 3'b111);

      // Output stall: OUT_READY low for 7 cycles after OUT_VALID.
      out_ready = 1'b0;
      run_block(vecs[0].key, vecs[0].pt, got, lat);
      check_v("stall_ct", got, vecs[0].ct);
      check_i("stall_latency", lat, 10);
      for (int i = 0; i < 7; i++) begin
         step();
         check_v($sformatf("stall_hold_ct_%0d", i), ct, vecs[0].ct);
         check_v($sformatf("stall_valid_%0d", i), {busy, out_valid, in_ready}, 3'b110);
      end
      out_ready = 1'b1;
      step();
      check_v("stall_release", {busy, out_valid, in_ready}, 3'b001);
      check_v("stall_ct_holds", ct, vecs[0].ct);

      // Back-to-back blocks with OUT_READY held high.
      key = vecs[0].key; pt = vecs[0].pt; in_valid = 1'b1;
      nacc = 0; nout = 0; acc_cyc = '{0, 0}; outs = '{'0, '0};
      for (int i = 0; i < 60 && nout < 2; i++) begin
         rdy_pre = in_ready;
         step();
         if (rdy_pre && in_valid && nacc < 2) begin
            acc_cyc[nacc] = i;
            nacc++;
            if (nacc == 1) begin
               key = vecs[1].key;
               pt = vecs[1].pt;
            end else begin
               in_valid = 1'b0;
            end
         end
         if (out_valid && nout < 2) begin
            outs[nout] = ct;
            nout++;
         end
      end
      in_valid = 1'b0;
      check_i("b2b_accepts", nacc, 2);
      check_i("b2b_gap", acc_cyc[1] - acc_cyc[0], 12);
      check_v("b2b_ct0", outs[0], vecs[0].ct);
      check_v("b2b_ct1", outs[1], vecs[1].ct);

      // Inputs churn while rounds are in progress.
      wait_ready();
      key = vecs[0].key; pt = vecs[0].pt; in_valid = 1'b1;
      step();
      lat = -1; got = '0;
      for (int i = 1; i <= 40 && lat < 0; i++) begin
         in_valid = ~in_valid;
         pt = {4{$urandom}};
         key = {4{$urandom}};
         step();
         if (out_valid) begin
            lat = i;
            got = ct;
         end
      end
      in_valid = 1'b0;
      check_v("churn_ct", got, vecs[0].ct);
      check_i("churn_latency", lat, 10);

      // Reset while the round counter sits at 5.
      wait_ready();
      key = vecs[1].key; pt = vecs[1].pt; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      check_v("mid_busy", {busy, out_valid, in_ready}, 3'b100);
      #2;
      rst_n = 1'b0;
      #1;
      check_v("mid_rst_flags", {busy, out_valid, in_ready}, 3'b000);
      check_v("mid_rst_cipher", ct, 0);
      step(); step();
      rst_n = 1'b1;
      #1;
      check_v("post_rst_ready", in_ready, 1);
      for (int i = 0; i < 12; i++) begin
         step();
         if (i == 11) check_v("post_rst_no_stale", {busy, out_valid}, 2'b00);
      end
      out_ready = 1'b1;
      run_block(vecs[1].key, vecs[1].pt, got, lat);
      check_v("post_rst_ct", got, vecs[1].ct);
      check_i("post_rst_latency", lat, 10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end
endmodule
